// File: rtl/ysyx_22050710_axi_bridge_pkg.sv
// Shared types and AXI constants for the SRAM-to-AXI bridge.
// The read FSM lives in the arbiter; the write FSM stays in the top.
package ysyx_22050710_axi_bridge_pkg;
    typedef enum logic [1:0] {R_IDLE, R_AR, R_WAIT} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_B}   wr_state_t;

    localparam int         AXI_ID_INST = 0;
    localparam int         AXI_ID_DATA = 1;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam int         SIZE_WD     = 3;
endpackage

// File: rtl/ysyx_22050710_axi_rd_arb.sv
// Read-side arbitration between inst and data ports and the single-beat AR/R FSM.
// The data port wins; data reads wait while a write is in flight so reads see it.
module ysyx_22050710_axi_rd_arb
    import ysyx_22050710_axi_bridge_pkg::*;
#(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 64,
    parameter int ID_WD   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_req,
    input  logic               inst_op,
    input  logic [SIZE_WD-1:0] inst_size,
    input  logic [ADDR_WD-1:0] inst_addr,
    input  logic               data_req,
    input  logic               data_op,
    input  logic [SIZE_WD-1:0] data_size,
    input  logic [ADDR_WD-1:0] data_addr,
    input  logic               wr_busy,
    output logic               inst_addr_ok,
    output logic               data_addr_ok,
    output logic               data_busy,
    output logic               arvalid,
    output logic [ID_WD-1:0]   arid,
    output logic [ADDR_WD-1:0] araddr,
    output logic [SIZE_WD-1:0] arsize,
    input  logic               arready,
    input  logic               rvalid,
    input  logic [ID_WD-1:0]   rid,
    input  logic [DATA_WD-1:0] rdata,
    output logic               rready,
    output logic               inst_data_ok,
    output logic [DATA_WD-1:0] inst_rdata,
    output logic               data_data_ok,
    output logic [DATA_WD-1:0] data_rdata
);
    rd_state_t state, state_n;
    logic      pick_data, pick_inst;

    assign pick_data = data_req & ~data_op & ~wr_busy;
    assign pick_inst = inst_req & ~inst_op & ~pick_data;
    assign arvalid   = (state == R_AR);
    assign rready    = (state == R_WAIT);
    // Lets the write FSM hold off a data write behind an outstanding data read.
    assign data_busy = (state != R_IDLE) && (arid == ID_WD'(AXI_ID_DATA));

    always_comb begin
        state_n      = state;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        case (state)
            R_IDLE: begin
                data_addr_ok = pick_data;
                inst_addr_ok = pick_inst;
                if (pick_data | pick_inst) state_n = R_AR;
            end
            R_AR:    if (arready) state_n = R_WAIT;
            R_WAIT:  if (rvalid)  state_n = R_IDLE;
            default: state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= R_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arid         <= '0;
            araddr       <= '0;
            arsize       <= '0;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            inst_rdata   <= '0;
            data_rdata   <= '0;
        end else begin
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            if (data_addr_ok) begin
                arid   <= ID_WD'(AXI_ID_DATA);
                araddr <= data_addr;
                arsize <= data_size;
            end else if (inst_addr_ok) begin
                arid   <= ID_WD'(AXI_ID_INST);
                araddr <= inst_addr;
                arsize <= inst_size;
            end
            if (rready && rvalid) begin
                if (rid == ID_WD'(AXI_ID_DATA)) begin
                    data_data_ok <= 1'b1;
                    data_rdata   <= rdata;
                end else begin
                    inst_data_ok <= 1'b1;
                    inst_rdata   <= rdata;
                end
            end
        end
    end
endmodule

// File: rtl/ysyx_22050710_axi_bridge.sv
// Bridges the core's inst/data SRAM-like ports onto one single-beat AXI4 master.
// One read and one write may be outstanding at a time.
module ysyx_22050710_axi_bridge
    import ysyx_22050710_axi_bridge_pkg::*;
#(
    parameter int SRAM_ADDR_WD  = 32,
    parameter int SRAM_DATA_WD  = 64,
    parameter int SRAM_WMASK_WD = 8,
    parameter int AXI_ID_WD     = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_inst_sram_req,
    input  logic                     i_inst_sram_op,
    input  logic [SIZE_WD-1:0]       i_inst_sram_size,
    input  logic [SRAM_ADDR_WD-1:0]  i_inst_sram_addr,
    input  logic [SRAM_WMASK_WD-1:0] i_inst_sram_wstrb,
    input  logic [SRAM_DATA_WD-1:0]  i_inst_sram_wdata,
    output logic                     o_inst_sram_addr_ok,
    output logic                     o_inst_sram_data_ok,
    output logic [SRAM_DATA_WD-1:0]  o_inst_sram_rdata,
    input  logic                     i_data_sram_req,
    input  logic                     i_data_sram_op,
    input  logic [SIZE_WD-1:0]       i_data_sram_size,
    input  logic [SRAM_ADDR_WD-1:0]  i_data_sram_addr,
    input  logic [SRAM_WMASK_WD-1:0] i_data_sram_wstrb,
    input  logic [SRAM_DATA_WD-1:0]  i_data_sram_wdata,
    output logic                     o_data_sram_addr_ok,
    output logic                     o_data_sram_data_ok,
    output logic [SRAM_DATA_WD-1:0]  o_data_sram_rdata,
    output logic                     o_axi_arvalid,
    output logic [AXI_ID_WD-1:0]     o_axi_arid,
    output logic [SRAM_ADDR_WD-1:0]  o_axi_araddr,
    output logic [7:0]               o_axi_arlen,
    output logic [SIZE_WD-1:0]       o_axi_arsize,
    output logic [1:0]               o_axi_arburst,
    input  logic                     i_axi_arready,
    input  logic                     i_axi_rvalid,
    input  logic [AXI_ID_WD-1:0]     i_axi_rid,
    input  logic [SRAM_DATA_WD-1:0]  i_axi_rdata,
    input  logic [1:0]               i_axi_rresp,
    input  logic                     i_axi_rlast,
    output logic                     o_axi_rready,
    output logic                     o_axi_awvalid,
    output logic [AXI_ID_WD-1:0]     o_axi_awid,
    output logic [SRAM_ADDR_WD-1:0]  o_axi_awaddr,
    output logic [7:0]               o_axi_awlen,
    output logic [SIZE_WD-1:0]       o_axi_awsize,
    output logic [1:0]               o_axi_awburst,
    input  logic                     i_axi_awready,
    output logic                     o_axi_wvalid,
    output logic [SRAM_DATA_WD-1:0]  o_axi_wdata,
    output logic [SRAM_WMASK_WD-1:0] o_axi_wstrb,
    output logic                     o_axi_wlast,
    input  logic                     i_axi_wready,
    input  logic                     i_axi_bvalid,
    input  logic [AXI_ID_WD-1:0]     i_axi_bid,
    input  logic [1:0]               i_axi_bresp,
    output logic                     o_axi_bready
);
    wr_state_t                wr_state, wr_state_n;
    logic                     rd_data_addr_ok, rd_data_busy, rd_data_ok;
    logic                     wr_addr_ok, wr_data_ok;
    logic                     aw_valid, w_valid;
    logic [SRAM_ADDR_WD-1:0]  aw_addr;
    logic [SIZE_WD-1:0]       aw_size;
    logic [SRAM_WMASK_WD-1:0] w_strb;
    logic [SRAM_DATA_WD-1:0]  w_data;
    logic                     unused_ok;

    // Single-beat only, responses are never checked, the inst port never writes.
    assign unused_ok = ^{i_inst_sram_wstrb, i_inst_sram_wdata, i_axi_rresp,
                         i_axi_rlast, i_axi_bid, i_axi_bresp};

    ysyx_22050710_axi_rd_arb #(
        .ADDR_WD (SRAM_ADDR_WD),
        .DATA_WD (SRAM_DATA_WD),
        .ID_WD   (AXI_ID_WD)
    ) u_rd_arb (
        .clk          (i_clk),
        .rst          (i_rst),
        .inst_req     (i_inst_sram_req),
        .inst_op      (i_inst_sram_op),
        .inst_size    (i_inst_sram_size),
        .inst_addr    (i_inst_sram_addr),
        .data_req     (i_data_sram_req),
        .data_op      (i_data_sram_op),
        .data_size    (i_data_sram_size),
        .data_addr    (i_data_sram_addr),
        .wr_busy      (wr_state != W_IDLE),
        .inst_addr_ok (o_inst_sram_addr_ok),
        .data_addr_ok (rd_data_addr_ok),
        .data_busy    (rd_data_busy),
        .arvalid      (o_axi_arvalid),
        .arid         (o_axi_arid),
        .araddr       (o_axi_araddr),
        .arsize       (o_axi_arsize),
        .arready      (i_axi_arready),
        .rvalid       (i_axi_rvalid),
        .rid          (i_axi_rid),
        .rdata        (i_axi_rdata),
        .rready       (o_axi_rready),
        .inst_data_ok (o_inst_sram_data_ok),
        .inst_rdata   (o_inst_sram_rdata),
        .data_data_ok (rd_data_ok),
        .data_rdata   (o_data_sram_rdata)
    );

    assign wr_addr_ok = (wr_state == W_IDLE) & i_data_sram_req & i_data_sram_op & ~rd_data_busy;

    assign o_data_sram_addr_ok = rd_data_addr_ok | wr_addr_ok;
    assign o_data_sram_data_ok = rd_data_ok | wr_data_ok;

    assign o_axi_arlen   = 8'd0;
    assign o_axi_arburst = BURST_INCR;
    assign o_axi_awvalid = aw_valid;
    assign o_axi_awid    = AXI_ID_WD'(AXI_ID_DATA);
    assign o_axi_awaddr  = aw_addr;
    assign o_axi_awlen   = 8'd0;
    assign o_axi_awsize  = aw_size;
    assign o_axi_awburst = BURST_INCR;
    assign o_axi_wvalid  = w_valid;
    assign o_axi_wdata   = w_data;
    assign o_axi_wstrb   = w_strb;
    assign o_axi_wlast   = 1'b1;
    assign o_axi_bready  = (wr_state == W_B);

    always_comb begin
        wr_state_n = wr_state;
        case (wr_state)
            W_IDLE: if (wr_addr_ok) wr_state_n = W_REQ;
            // AW and W retire independently; move on once neither is still pending.
            W_REQ: if ((~aw_valid | i_axi_awready) & (~w_valid | i_axi_wready)) wr_state_n = W_B;
            W_B:     if (i_axi_bvalid) wr_state_n = W_IDLE;
            default: wr_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) wr_state <= W_IDLE;
        else       wr_state <= wr_state_n;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            aw_valid   <= 1'b0;
            w_valid    <= 1'b0;
            aw_addr    <= '0;
            aw_size    <= '0;
            w_strb     <= '0;
            w_data     <= '0;
            wr_data_ok <= 1'b0;
        end else begin
            wr_data_ok <= (wr_state == W_B) & i_axi_bvalid;
            if (wr_addr_ok) begin
                aw_valid <= 1'b1;
                w_valid  <= 1'b1;
                aw_addr  <= i_data_sram_addr;
                aw_size  <= i_data_sram_size;
                w_strb   <= i_data_sram_wstrb;
                w_data   <= i_data_sram_wdata;
            end else begin
                if (i_axi_awready) aw_valid <= 1'b0;
                if (i_axi_wready)  w_valid  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22050710_axi_bridge.sv
// Directed bench for the AXI bridge: the bench plays both the core and the AXI slave.
module tb_ysyx_22050710_axi_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_op, data_req, data_op;
    logic [2:0]  inst_size, data_size;
    logic [31:0] inst_addr, data_addr;
    logic [7:0]  inst_wstrb, data_wstrb;
    logic [63:0] inst_wdata, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [63:0] inst_rdata, data_rdata;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [3:0]  arid, rid, awid, bid;
    logic [31:0] araddr, awaddr;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic [63:0] rdata, wdata;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [7:0]  wstrb;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22050710_axi_bridge dut (
        .i_clk(clk), .i_rst(rst),
        .i_inst_sram_req(inst_req), .i_inst_sram_op(inst_op), .i_inst_sram_size(inst_size),
        .i_inst_sram_addr(inst_addr), .i_inst_sram_wstrb(inst_wstrb), .i_inst_sram_wdata(inst_wdata),
        .o_inst_sram_addr_ok(inst_addr_ok), .o_inst_sram_data_ok(inst_data_ok),
        .o_inst_sram_rdata(inst_rdata),
        .i_data_sram_req(data_req), .i_data_sram_op(data_op), .i_data_sram_size(data_size),
        .i_data_sram_addr(data_addr), .i_data_sram_wstrb(data_wstrb), .i_data_sram_wdata(data_wdata),
        .o_data_sram_addr_ok(data_addr_ok), .o_data_sram_data_ok(data_data_ok),
        .o_data_sram_rdata(data_rdata),
        .o_axi_arvalid(arvalid), .o_axi_arid(arid), .o_axi_araddr(araddr), .o_axi_arlen(arlen),
        .o_axi_arsize(arsize), .o_axi_arburst(arburst), .i_axi_arready(arready),
        .i_axi_rvalid(rvalid), .i_axi_rid(rid), .i_axi_rdata(rdata), .i_axi_rresp(rresp),
        .i_axi_rlast(rlast), .o_axi_rready(rready),
        .o_axi_awvalid(awvalid), .o_axi_awid(awid), .o_axi_awaddr(awaddr), .o_axi_awlen(awlen),
        .o_axi_awsize(awsize), .o_axi_awburst(awburst), .i_axi_awready(awready),
        .o_axi_wvalid(wvalid), .o_axi_wdata(wdata), .o_axi_wstrb(wstrb), .o_axi_wlast(wlast),
        .i_axi_wready(wready),
        .i_axi_bvalid(bvalid), .i_axi_bid(bid), .i_axi_bresp(bresp), .o_axi_bready(bready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req = 0; inst_op = 0; inst_size = 3'd3; inst_addr = '0; inst_wstrb = '0; inst_wdata = '0;
        data_req = 0; data_op = 0; data_size = 3'd3; data_addr = '0; data_wstrb = '0; data_wdata = '0;
        arready = 0; rvalid = 0; rid = '0; rdata = '0; rresp = '0; rlast = 1;
        awready = 0; wready = 0; bvalid = 0; bid = 4'd1; bresp = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".valids"}, {arvalid, awvalid, wvalid}, 3'b000);
        chk({tag, ".readys"}, {rready, bready}, 2'b00);
        chk({tag, ".oks"}, {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0000);
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        #2;
        chk_quiet("reset");
        chk("reset.irdata", inst_rdata, 64'h0);
        chk("reset.drdata", data_rdata, 64'h0);
        nx(); rst = 0;

        // 1: single inst read
        inst_req = 1; inst_addr = 32'h8000_0000; #2;
        chk("t1.iaok", inst_addr_ok, 1); chk("t1.daok", data_addr_ok, 0);
        nx(); inst_req = 0; arready = 1; #2;
        chk("t1.arvalid", arvalid, 1); chk("t1.araddr", araddr, 32'h8000_0000);
        chk("t1.arid", arid, 0); chk("t1.arsize", arsize, 3);
        chk("t1.arlen_burst", {arlen, arburst}, {8'd0, 2'b01});
        nx(); arready = 0; rvalid = 1; rid = 0; rdata = 64'h13; #2;
        chk("t1.rready", rready, 1); chk("t1.arvalid_lo", arvalid, 0);
        nx(); rvalid = 0; #2;
        chk("t1.idok", inst_data_ok, 1); chk("t1.irdata", inst_rdata, 64'h13);
        chk("t1.ddok", data_data_ok, 0); chk("t1.rready_lo", rready, 0);
        nx(); #2;
        chk("t1.idok_pulse", inst_data_ok, 0); chk("t1.irdata_hold", inst_rdata, 64'h13);

        // 2: inst and data reads together, data wins
        inst_req = 1; inst_addr = 32'h8000_0008;
        data_req = 1; data_op = 0; data_addr = 32'h8000_1000; #2;
        chk("t2.daok", data_addr_ok, 1); chk("t2.iaok", inst_addr_ok, 0);
        nx(); data_req = 0; arready = 1; #2;
        chk("t2.arid_d", arid, 1); chk("t2.araddr_d", araddr, 32'h8000_1000);
        chk("t2.iaok_busy", inst_addr_ok, 0);
        nx(); arready = 0; rvalid = 1; rid = 1; rdata = 64'hD1; #2;
        chk("t2.iaok_wait", inst_addr_ok, 0);
        nx(); rvalid = 0; #2;
        chk("t2.ddok", data_data_ok, 1); chk("t2.drdata", data_rdata, 64'hD1);
        chk("t2.idok", inst_data_ok, 0); chk("t2.iaok_now", inst_addr_ok, 1);
        nx(); inst_req = 0; arready = 1; #2;
        chk("t2.arid_i", arid, 0); chk("t2.araddr_i", araddr, 32'h8000_0008);
        nx(); arready = 0; rvalid = 1; rid = 0; rdata = 64'h22;
        nx(); rvalid = 0; #2;
        chk("t2.idok2", inst_data_ok, 1); chk("t2.irdata2", inst_rdata, 64'h22);
        chk("t2.drdata_hold", data_rdata, 64'hD1);
        nx();

        // 3: data write, W accepted three cycles before AW
        data_req = 1; data_op = 1; data_addr = 32'h8000_0100; data_wstrb = 8'hFF;
        data_wdata = 64'h1122_3344_5566_7788; #2;
        chk("t3.daok", data_addr_ok, 1);
        nx(); data_req = 0; wready = 1; #2;
        chk("t3.aw_w", {awvalid, wvalid}, 2'b11); chk("t3.awaddr", awaddr, 32'h8000_0100);
        chk("t3.wstrb", wstrb, 8'hFF); chk("t3.wdata", wdata, 64'h1122_3344_5566_7788);
        chk("t3.wlast", wlast, 1); chk("t3.awid", awid, 1);
        nx(); wready = 0; #2;
        chk("t3.wdrop", {awvalid, wvalid}, 2'b10);
        nx(); #2;
        chk("t3.awhold", {awvalid, wvalid, bready}, 3'b100);
        nx(); awready = 1; #2;
        chk("t3.awhold2", awvalid, 1);
        nx(); awready = 0; bvalid = 1; #2;
        chk("t3.bphase", {awvalid, wvalid, bready}, 3'b001); chk("t3.ddok_early", data_data_ok, 0);
        nx(); bvalid = 0; #2;
        chk("t3.ddok", data_data_ok, 1); chk("t3.bready_lo", bready, 0);
        nx(); #2;
        chk("t3.ddok_pulse", data_data_ok, 0);

        // 4: data read blocked behind a write, inst read goes ahead
        data_req = 1; data_op = 1; data_addr = 32'h8000_0200; data_wdata = 64'h5; #2;
        chk("t4.waok", data_addr_ok, 1);
        nx(); data_op = 0; data_addr = 32'h8000_0300;
        inst_req = 1; inst_addr = 32'h8000_0004; awready = 1; wready = 1; #2;
        chk("t4.rd_block", data_addr_ok, 0); chk("t4.iaok", inst_addr_ok, 1);
        nx(); inst_req = 0; awready = 0; wready = 0; arready = 1; #2;
        chk("t4.rd_block2", data_addr_ok, 0); chk("t4.arid_i", {arvalid, arid}, {1'b1, 4'd0});
        nx(); arready = 0; rvalid = 1; rid = 0; rdata = 64'h33; bvalid = 1; #2;
        chk("t4.rd_block3", data_addr_ok, 0);
        nx(); rvalid = 0; bvalid = 0; #2;
        chk("t4.both_ok", {inst_data_ok, data_data_ok}, 2'b11);
        chk("t4.irdata", inst_rdata, 64'h33); chk("t4.daok", data_addr_ok, 1);
        nx(); data_req = 0; arready = 1; #2;
        chk("t4.arid_d", arid, 1); chk("t4.araddr_d", araddr, 32'h8000_0300);
        nx(); arready = 0; rvalid = 1; rid = 1; rdata = 64'h44;
        nx(); rvalid = 0; #2;
        chk("t4.ddok", data_data_ok, 1); chk("t4.drdata", data_rdata, 64'h44);
        nx();

        // 5: arready held low, AR fields stay put and no extra accept
        inst_req = 1; inst_addr = 32'h8000_0040; inst_size = 3'd2; #2;
        chk("t5.iaok", inst_addr_ok, 1);
        for (int i = 0; i < 10; i++) begin
            nx(); inst_addr = 32'h8000_0080; inst_size = 3'd3; #2;
            chk("t5.ar_stable", {arvalid, arid, araddr, arsize},
                {1'b1, 4'd0, 32'h8000_0040, 3'd2});
            chk("t5.no_iaok", inst_addr_ok, 0);
        end
        nx(); inst_req = 0; arready = 1;
        nx(); arready = 0; rvalid = 1; rid = 0; rdata = 64'h77;
        nx(); rvalid = 0; #2;
        chk("t5.idok", {inst_data_ok, inst_rdata}, {1'b1, 64'h77});
        nx();

        // 6: async reset with a read in R_WAIT and a write in W_REQ
        inst_req = 1; inst_addr = 32'h8000_0010;
        data_req = 1; data_op = 1; data_addr = 32'h8000_0400; #2;
        chk("t6.aoks", {inst_addr_ok, data_addr_ok}, 2'b11);
        nx(); inst_req = 0; data_req = 0; arready = 1;
        nx(); arready = 0; #2;
        chk("t6.pre", {rready, awvalid, wvalid}, 3'b111);
        rst = 1; #1;
        chk_quiet("t6.rst");
        chk("t6.drdata_rst", data_rdata, 64'h0);
        nx(); rst = 0;
        inst_req = 1; inst_addr = 32'h8000_0020; #2;
        chk("t6.iaok_post", inst_addr_ok, 1);
        nx(); inst_req = 0; arready = 1; #2;
        chk("t6.araddr_post", araddr, 32'h8000_0020);
        nx(); arready = 0; rvalid = 1; rid = 0; rdata = 64'h55;
        nx(); rvalid = 0; #2;
        chk("t6.idok_post", {inst_data_ok, inst_rdata}, {1'b1, 64'h55});
        chk("t6.no_wr", {awvalid, wvalid, bready}, 3'b000);
        nx();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
